// File: rtl/blood_pkg.sv
// Shared constants and flash state encoding for the blood-bar sprite reader.
package blood_pkg;

    localparam int unsigned SPRITE_DIM   = 64;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned COLOR_W      = 12;
    localparam logic [11:0] TRANSPARENT  = 12'h000;
    localparam int unsigned FLASH_FRAMES = 30;
    localparam int unsigned BLINK_FRAMES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFlashOn,
        StFlashOff
    } flash_state_e;

endpackage

// File: rtl/blood_flash_fsm.sv
// Hit-flash sequencer: after a hit the sprite blinks on/off for a fixed number of frames.
module blood_flash_fsm
    import blood_pkg::*;
#(
    parameter int unsigned FlashFrames = FLASH_FRAMES,
    parameter int unsigned BlinkFrames = BLINK_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic hit,
    output logic vis
);

    localparam int unsigned TotW   = $clog2(FlashFrames);
    localparam int unsigned BlinkW = $clog2(BlinkFrames);

    flash_state_e      state_q, state_d;
    logic [TotW-1:0]   total_q, total_d;
    logic [BlinkW-1:0] blink_q, blink_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            total_q <= '0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        blink_d = blink_q;
        // A hit always restarts the sequence, even on a frame_tick cycle.
        if (hit) begin
            state_d = StFlashOn;
            total_d = '0;
            blink_d = '0;
        end else if (frame_tick && state_q != StIdle) begin
            if (total_q == TotW'(FlashFrames - 1)) begin
                state_d = StIdle;
                total_d = '0;
                blink_d = '0;
            end else begin
                total_d = total_q + 1'b1;
                if (blink_q == BlinkW'(BlinkFrames - 1)) begin
                    blink_d = '0;
                    state_d = (state_q == StFlashOn) ? StFlashOff : StFlashOn;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
        end
    end

    assign vis = (state_q != StFlashOff);

endmodule

// File: rtl/blood_sprite_reader.sv
// Maps the VGA scan position onto the blood-bar sprite ROM and produces the cropped,
// transparency-keyed, hit-flashing pixel two clocks later.
module blood_sprite_reader
    import blood_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [6:0]         health,
    input  logic               hit,
    output logic [ADDR_W-1:0]  rom_row,
    output logic [ADDR_W-1:0]  rom_col,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               pixel_on,
    output logic [COLOR_W-1:0] rgb_out
);

    logic [9:0]         px_q, py_q;
    logic [6:0]         health_q;
    logic               draw_q;
    logic               pixel_on_q;
    logic [COLOR_W-1:0] rgb_q;
    logic               vis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q     <= '0;
            py_q     <= '0;
            health_q <= '0;
        end else if (frame_tick) begin
            px_q     <= pos_x;
            py_q     <= pos_y;
            health_q <= (health > 7'(SPRITE_DIM)) ? 7'(SPRITE_DIM) : health;
        end
    end

    // 11-bit compares so a sprite near the right/bottom edge clips rather than wraps.
    logic [10:0]       x_e, y_e, px_e, py_e;
    logic              in_win, crop;
    logic [ADDR_W-1:0] dx, dy;

    always_comb begin
        x_e    = {1'b0, x};
        y_e    = {1'b0, y};
        px_e   = {1'b0, px_q};
        py_e   = {1'b0, py_q};
        in_win = video_on
                 && (x_e >= px_e) && (x_e < px_e + 11'(SPRITE_DIM))
                 && (y_e >= py_e) && (y_e < py_e + 11'(SPRITE_DIM));
        dx     = x[ADDR_W-1:0] - px_q[ADDR_W-1:0];
        dy     = y[ADDR_W-1:0] - py_q[ADDR_W-1:0];
        crop   = {1'b0, dx} < health_q;
        rom_row = in_win ? dy : '0;
        rom_col = in_win ? dx : '0;
    end

    blood_flash_fsm u_flash (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .hit        (hit),
        .vis        (vis)
    );

    logic pixel_d;
    assign pixel_d = draw_q && vis && (rom_data != TRANSPARENT);

    // draw_q lines up with the ROM address register; the output stage meets rom_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            draw_q     <= 1'b0;
            pixel_on_q <= 1'b0;
            rgb_q      <= '0;
        end else begin
            draw_q     <= in_win && crop;
            pixel_on_q <= pixel_d;
            rgb_q      <= pixel_d ? rom_data : '0;
        end
    end

    assign pixel_on = pixel_on_q;
    assign rgb_out  = rgb_q;

endmodule

// File: tb/tb_blood_sprite_reader.sv
// Directed bench for blood_sprite_reader with a registered ROM model.
module tb_blood_sprite_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic [9:0]  pos_x, pos_y;
    logic [6:0]  health;
    logic        hit;
    logic [5:0]  rom_row, rom_col;
    logic [11:0] rom_data = 12'h000;
    logic        pixel_on;
    logic [11:0] rgb_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    blood_sprite_reader dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .health     (health),
        .hit        (hit),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .pixel_on   (pixel_on),
        .rgb_out    (rgb_out)
    );

    // Row 9 is transparent, (2,3) is red, everything else a nonzero row/col pattern.
    function automatic logic [11:0] rom_fn(input logic [5:0] r, input logic [5:0] c);
        if (r == 6'd2 && c == 6'd3) return 12'hE00;
        if (r == 6'd9) return 12'h000;
        return {r, c} | 12'h001;
    endfunction

    always_ff @(posedge clk) rom_data <= rom_fn(rom_row, rom_col);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input int px, input int py, input int h);
        @(posedge clk); #1;
        pos_x = 10'(px); pos_y = 10'(py); health = 7'(h); frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_hit();
        @(posedge clk); #1;
        hit = 1'b1;
        @(posedge clk); #1;
        hit = 1'b0;
    endtask

    // Single pixel: check addresses the same cycle, output two edges later.
    task automatic pix(input string tag, input int px, input int py, input int er, input int ec,
                       input logic eon, input logic [11:0] ergb);
        @(posedge clk); #1;
        x = 10'(px); y = 10'(py); video_on = 1'b1;
        #1;
        check_eq({tag, ".row"}, 32'(rom_row), 32'(er));
        check_eq({tag, ".col"}, 32'(rom_col), 32'(ec));
        @(posedge clk); #1;
        video_on = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, ".on"}, 32'(pixel_on), 32'(eon));
        check_eq({tag, ".rgb"}, 32'(rgb_out), 32'(ergb));
    endtask

    // Continuous scan of an nx-by-ny block, counting cycles with pixel_on.
    task automatic scan(input int x0, input int nx, input int y0, input int ny, output int cnt);
        cnt = 0;
        for (int i = 0; i < nx * ny + 2; i++) begin
            @(posedge clk); #1;
            if (pixel_on) cnt++;
            if (i < nx * ny) begin
                x = 10'(x0 + i % nx); y = 10'(y0 + i / nx); video_on = 1'b1;
            end else begin
                video_on = 1'b0;
            end
        end
    endtask

    function automatic logic exp_vis(input int k);
        if (k >= 30) return 1'b1;
        return ((k / 4) % 2) == 0;
    endfunction

    initial begin
        int cnt;
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; health = '0; hit = 1'b0;
        #12;
        check_eq("rst.on", 32'(pixel_on), 32'd0);
        check_eq("rst.rgb", 32'(rgb_out), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Latched health is 0 until the first frame_tick.
        pix("prefrm", 3, 2, 2, 3, 1'b0, 12'h000);

        do_frame(100, 50, 64);
        pix("lat", 103, 52, 2, 3, 1'b1, 12'hE00);
        pix("outside", 99, 52, 0, 0, 1'b0, 12'h000);
        pix("transp", 103, 59, 9, 3, 1'b0, 12'h000);

        do_frame(100, 50, 20);
        pix("crop19", 119, 52, 2, 19, 1'b1, 12'h093);
        pix("crop20", 120, 52, 2, 20, 1'b0, 12'h000);

        do_frame(100, 50, 100);
        pix("h100.63", 163, 52, 2, 63, 1'b1, 12'h0BF);
        pix("h100.64", 164, 52, 0, 0, 1'b0, 12'h000);

        do_frame(100, 50, 0);
        scan(100, 64, 50, 64, cnt);
        check_eq("h0.count", 32'(cnt), 32'd0);

        do_frame(1000, 0, 64);
        scan(1000, 24, 5, 1, cnt);
        check_eq("edge.count", 32'(cnt), 32'd24);
        scan(0, 64, 5, 1, cnt);
        check_eq("edge.wrap", 32'(cnt), 32'd0);

        // Full flash sequence.
        do_frame(100, 50, 64);
        do_hit();
        pix("fl.0", 103, 52, 2, 3, 1'b1, 12'hE00);
        for (int k = 1; k <= 31; k++) begin
            do_frame(100, 50, 64);
            pix($sformatf("fl.%0d", k), 103, 52, 2, 3, exp_vis(k), exp_vis(k) ? 12'hE00 : 12'h000);
        end

        // Second hit at frame 10 restarts with a visible phase.
        do_hit();
        for (int k = 1; k <= 10; k++) do_frame(100, 50, 64);
        do_hit();
        for (int k = 1; k <= 8; k++) begin
            do_frame(100, 50, 64);
            pix($sformatf("rh.%0d", k), 103, 52, 2, 3, exp_vis(k), exp_vis(k) ? 12'hE00 : 12'h000);
        end

        // Async reset while drawing.
        @(posedge clk); #1;
        x = 10'd103; y = 10'd52; video_on = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("pre_rst.on", 32'(pixel_on), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("async.on", 32'(pixel_on), 32'd0);
        check_eq("async.rgb", 32'(rgb_out), 32'd0);
        video_on = 1'b0;
        @(negedge clk); reset = 1'b0;
        scan(0, 64, 0, 2, cnt);
        check_eq("postrst.count", 32'(cnt), 32'd0);
        do_frame(100, 50, 64);
        pix("postfrm", 103, 52, 2, 3, 1'b1, 12'hE00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blood_sprite_reader.md
Name: blood_sprite_reader

Overview:
- Reader side of the 64x64, 12-bit blood-bar sprite ROMs (the ROM registers row/col and returns color_data one clock later).
- Takes the VGA scan position and produces ROM row/col addresses. Aligns the returned pixel with the ROM's 1-cycle latency, applies transparency, crops horizontally by current health, and blinks the sprite after a hit.
- Sits between the VGA sync/pixel generator and the top-level RGB mux, one instance per fighter health bar.

Parameters:
- SPRITE_DIM, 64, sprite width/height in pixels; the address fields are 6 bits wide.
- TRANSPARENT, 12'h000, ROM color treated as "no pixel".
- FLASH_FRAMES, 30, total frames of hit flashing.
- BLINK_FRAMES, 4, frames per on/off half-period while flashing.

Ports:
- clk  input  1  system/pixel clock; one pixel per clock.
- reset  input  1  asynchronous, active-high reset.
- video_on  input  1  scan position is in the visible area.
- x  input  10  current scan column.
- y  input  10  current scan row.
- frame_tick  input  1  one-cycle pulse at start of vertical blank.
- pos_x  input  10  sprite top-left column; sampled at frame_tick.
- pos_y  input  10  sprite top-left row; sampled at frame_tick.
- health  input  7  visible width in pixels (0..64; values above 64 are clamped to 64); sampled at frame_tick.
- hit  input  1  one-cycle damage pulse.
- rom_row  output  6  ROM row address.
- rom_col  output  6  ROM column address.
- rom_data  input  12  ROM color_data, valid one clock after the address.
- pixel_on  output  1  sprite pixel is opaque at the delayed position.
- rgb_out  output  12  sprite color; 0 when pixel_on=0.

Behaviour:
- Reset values:
  - pixel_on=0, rgb_out=0.
  - Latched pos_x, pos_y and health = 0.
  - Flash FSM in IDLE, frame counters 0.
- Frame latch: on a clock with frame_tick=1, capture pos_x, pos_y and min(health,64). The latched values stay stable for the whole frame, so there is no mid-frame tearing.
- Window test (combinational, cycle N):
  - in_win = video_on && x >= px && x < px+64 && y >= py && y < py+64.
  - Sums are computed at 11 bits, so a sprite near x=1023 clips instead of wrapping.
  - crop = (x-px) < health_l. With health_l=0 nothing is drawn.
- Addresses (cycle N): rom_row=(y-py)[5:0], rom_col=(x-px)[5:0] when in_win; otherwise both 0.
- Pipeline:
  - Stage 1 registers in_win&&crop into draw_d1 at the same edge the ROM registers the address.
  - At edge N+2: pixel_on <= draw_d1 && vis && rom_data!=TRANSPARENT; rgb_out <= pixel_on-condition ? rom_data : 0.
  - Total latency is 2 clocks from x/y to pixel_on/rgb_out; the upstream pixel generator delays sync by 2 accordingly.
- Flash FSM (advances only on frame_tick; hit is checked every clock):
  - IDLE: vis=1. hit -> FLASH_ON, total_cnt=0, blink_cnt=0.
  - FLASH_ON: vis=1. At frame_tick: total_cnt++, blink_cnt++. When blink_cnt reaches BLINK_FRAMES-1 -> FLASH_OFF, blink_cnt=0.
  - FLASH_OFF: vis=0, with the same counting. When blink_cnt reaches BLINK_FRAMES-1 -> FLASH_ON.
  - From either flash state: at frame_tick when total_cnt reaches FLASH_FRAMES-1 -> IDLE.
  - hit during FLASH_ON/FLASH_OFF: restart at FLASH_ON with both counters 0. Hit takes priority over frame_tick in the same cycle.
- Changes in vis take effect at the next draw, and only at frame boundaries. Because frame_tick falls in blank, no partial-frame blink occurs.
- Reset mid-frame: outputs drop to 0 immediately (async). Nothing is drawn until the first frame_tick after reset, since the latched health is 0.

Decomposition:
- Shared package (blood_pkg): SPRITE_DIM, ADDR_W=6, COLOR_W=12, TRANSPARENT, flash state encoding {IDLE, FLASH_ON, FLASH_OFF}.
- One sub-module, blood_flash_fsm: inputs clk, reset, frame_tick, hit; output vis. It holds both counters.
- Window/address logic and the pipeline stay in the top module.

Test Plan:
- Latency: pos=(100,50), health=64, frame_tick, then drive x=103,y=52 with the ROM model returning 12'hE00 for (2,3). Expect rom_row=2, rom_col=3 same cycle, and pixel_on=1, rgb_out=12'hE00 exactly 2 clocks later.
- Transparency/outside: at x=99,y=52, expect rom_row=rom_col=0 and pixel_on=0. At an in-window pixel where the ROM returns 12'h000, expect pixel_on=0, rgb_out=0.
- Health crop: health=20 latched. Column offset 19 gives pixel_on=1 (opaque data); offset 20 gives pixel_on=0. Health=100 behaves like 64. Health=0 gives no pixels in the entire frame.
- Edge clip: pos_x=1000, x sweep 1000..1023. Expect drawing at all 24 columns and no wrap to x<64.
- Flash: hit pulse, then count frame_ticks. Expect visible for 4 frames, hidden for 4, and so on, back to IDLE steady-on after 30 frames. A second hit at frame 10 restarts the sequence (visible for 4 frames).
- Reset: assert reset mid-line while pixel_on=1. Expect pixel_on=0, rgb_out=0 without waiting for a clock edge. No draws occur until the next frame_tick with nonzero health.
